// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter
//   Shares one 4-digit FND display between three requesters. A winner is
//   picked round-robin, owns the display for up to HOLD_CYCLES cycles, and
//   its value is live-refreshed while it keeps its request up. The slot is
//   released early when the owner drops its request and somebody else waits.
//
//   Optional feature macro: FND_ARB_PRIO0_EN
//     When defined, requester 0 is high priority: it wins every ARB cycle it
//     requests in, and it preempts another owner's HOLD slot.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [2:0] per-requester request, bit i = requester i
//   req_data0  in   [13:0] binary value from requester 0
//   req_data1  in   [13:0] binary value from requester 1
//   req_data2  in   [13:0] binary value from requester 2
//   req_grant  out  [2:0] one-hot grant pulse, first HOLD cycle only
//   disp_value out  [13:0] value for the FND counter, saturated to 9999
//   disp_src   out  [1:0] index of the current owner
//   disp_valid out  high once any grant has occurred
module fnd_display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [13:0] req_data0,
  input  logic [13:0] req_data1,
  input  logic [13:0] req_data2,
  output logic [2:0]  req_grant,
  output logic [13:0] disp_value,
  output logic [1:0]  disp_src,
  output logic        disp_valid
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int CW = $clog2(HOLD_CYCLES);

  logic [0:0]    state;
  logic [1:0]    owner;
  logic [1:0]    last;
  logic [CW-1:0] hold_cnt;

  logic [1:0]  c0, c1, c2;
  logic [1:0]  win;
  logic [13:0] win_data;
  logic [13:0] own_data;
  logic        own_vld;
  logic        others_vld;
  logic        expire;
  logic        preempt;

  function automatic logic [13:0] sat(input logic [13:0] x);
    return (x > 14'd9999) ? 14'd9999 : x;
  endfunction

  // Search order starts just after the last winner and wraps.
  always_comb begin
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
  end

  always_comb begin
    if (req_valid[c0])      win = c0;
    else if (req_valid[c1]) win = c1;
    else                    win = c2;
`ifdef FND_ARB_PRIO0_EN
    if (req_valid[0]) win = 2'd0;
`endif
  end

  always_comb begin
    case (win)
      2'd0:    win_data = req_data0;
      2'd1:    win_data = req_data1;
      default: win_data = req_data2;
    endcase
  end

  // Only the owner's data path is ever sampled during HOLD.
  always_comb begin
    case (owner)
      2'd0:    own_data = req_data0;
      2'd1:    own_data = req_data1;
      default: own_data = req_data2;
    endcase
  end

  assign own_vld    = req_valid[owner];
  assign others_vld = |(req_valid & ~(3'b001 << owner));
  assign expire     = (hold_cnt == CW'(HOLD_CYCLES - 1));

`ifdef FND_ARB_PRIO0_EN
  assign preempt = (owner != 2'd0) && req_valid[0];
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARB;
      owner      <= 2'd0;
      last       <= 2'd2;   // requester 0 wins the first pass
      hold_cnt   <= '0;
      req_grant  <= 3'b000;
      disp_value <= 14'd0;
      disp_valid <= 1'b0;
    end else begin
      req_grant <= 3'b000;
      case (state)
        ST_ARB: begin
          if (|req_valid) begin
            disp_value <= sat(win_data);
            owner      <= win;
            last       <= win;
            disp_valid <= 1'b1;
            req_grant  <= 3'b001 << win;
            hold_cnt   <= '0;
            state      <= ST_HOLD;
          end
        end
        default: begin
          hold_cnt <= hold_cnt + CW'(1);
          if (own_vld)
            disp_value <= sat(own_data);
          // Early release only when the owner has let go and someone waits.
          if (expire || (!own_vld && others_vld) || preempt)
            state <= ST_ARB;
        end
      endcase
    end
  end

  assign disp_src = owner;

endmodule
